// File: rtl/if_id_buffer.sv
// Fetch-to-decode decoupling buffer: circular FIFO of {PC, instruction, misaligned} entries.
// One-cycle fill latency, no bypass; fetch_ready_o comes only from registered occupancy.
module if_id_buffer #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       fetch_valid_i,
  output logic                       fetch_ready_o,
  input  logic [XLEN-1:0]            fetch_pc_i,
  input  logic [ILEN-1:0]            fetch_instr_i,
  output logic                       decode_valid_o,
  input  logic                       decode_ready_i,
  output logic [XLEN-1:0]            decode_pc_o,
  output logic [ILEN-1:0]            decode_instr_o,
  output logic                       decode_misaligned_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            misaligned;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;
  entry_t          head;

  assign fetch_ready_o  = (count_q != CW'(DEPTH));
  assign decode_valid_o = (count_q != '0);

  // Flush suppresses both handshakes so the redirect wins over any transfer.
  assign push = fetch_valid_i && fetch_ready_o && !flush_i;
  assign pop  = decode_valid_o && decode_ready_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc: fetch_pc_i, instr: fetch_instr_i, misaligned: |fetch_pc_i[1:0]};
    end
  end

  always_comb begin
    head = '0;
    if (decode_valid_o) head = mem_q[rd_ptr_q];
  end

  assign decode_pc_o         = head.pc;
  assign decode_instr_o      = head.instr;
  assign decode_misaligned_o = head.misaligned;
  assign count_o             = count_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer with hand-computed expectations.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [63:0] fetch_pc_i;
  logic [31:0] fetch_instr_i;
  logic        decode_valid_o;
  logic        decode_ready_i;
  logic [63:0] decode_pc_o;
  logic [31:0] decode_instr_o;
  logic        decode_misaligned_o;
  logic [1:0]  count_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  if_id_buffer #(.XLEN(64), .ILEN(32), .DEPTH(2)) dut (
    .clk                 (clk),
    .reset               (reset),
    .flush_i             (flush_i),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_ready_o       (fetch_ready_o),
    .fetch_pc_i          (fetch_pc_i),
    .fetch_instr_i       (fetch_instr_i),
    .decode_valid_o      (decode_valid_o),
    .decode_ready_i      (decode_ready_i),
    .decode_pc_o         (decode_pc_o),
    .decode_instr_o      (decode_instr_o),
    .decode_misaligned_o (decode_misaligned_o),
    .count_o             (count_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i = 1'b0; fetch_valid_i = 1'b0; decode_ready_i = 1'b0;
    fetch_pc_i = '0; fetch_instr_i = '0;
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] instr);
    fetch_valid_i = 1'b1; fetch_pc_i = pc; fetch_instr_i = instr;
    step();
    fetch_valid_i = 1'b0;
  endtask

  task automatic clear();
    flush_i = 1'b1;
    step();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    #2;
    vectors++; if (count_o !== 2'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count_o); end
    vectors++; if (fetch_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", fetch_ready_o); end
    step();
    reset = 1'b0;
    step();
    vectors++; if (decode_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_release_valid: got %b want 0", decode_valid_o); end
    push(64'h1000, 32'h13);
    push(64'h1004, 32'h13);
    vectors++; if (count_o !== 2'd2) begin miscompares++; $display("FAIL prereset_count: got %0d want 2", count_o); end
    reset = 1'b1;
    #1;
    vectors++; if (decode_valid_o !== 1'b0) begin miscompares++; $display("FAIL async_valid: got %b want 0", decode_valid_o); end
    vectors++; if (count_o !== 2'd0) begin miscompares++; $display("FAIL async_count: got %0d want 0", count_o); end
    vectors++; if (fetch_ready_o !== 1'b1) begin miscompares++; $display("FAIL async_ready: got %b want 1", fetch_ready_o); end
    vectors++; if ({decode_pc_o, decode_instr_o, decode_misaligned_o} !== 97'd0) begin
      miscompares++; $display("FAIL async_data: got pc=%h instr=%h mis=%b want 0", decode_pc_o, decode_instr_o, decode_misaligned_o);
    end
    step();
    reset = 1'b0;
    step();
    vectors++; if (count_o !== 2'd0) begin miscompares++; $display("FAIL post_reset_count: got %0d want 0", count_o); end
  endtask

  task automatic test_single_pass();
    push(64'h1000, 32'h00000013);
    vectors++; if (decode_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", decode_valid_o); end
    vectors++; if (count_o !== 2'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", count_o); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (decode_pc_o !== 64'h1000 || decode_instr_o !== 32'h13) begin
        miscompares++; $display("FAIL single_hold%0d: got pc=%h instr=%h want 1000/00000013", i, decode_pc_o, decode_instr_o);
      end
      step();
    end
    decode_ready_i = 1'b1;
    step();
    decode_ready_i = 1'b0;
    vectors++; if (decode_valid_o !== 1'b0 || count_o !== 2'd0) begin
      miscompares++; $display("FAIL single_drain: got valid=%b count=%0d want 0/0", decode_valid_o, count_o);
    end
  endtask

  task automatic test_fill();
    push(64'h1000, 32'h13);
    push(64'h1004, 32'h13);
    vectors++; if (count_o !== 2'd2 || fetch_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL full_state: got count=%0d ready=%b want 2/0", count_o, fetch_ready_o);
    end
    push(64'h1008, 32'h13);
    vectors++; if (count_o !== 2'd2 || decode_pc_o !== 64'h1000) begin
      miscompares++; $display("FAIL full_refuse: got count=%0d pc=%h want 2/1000", count_o, decode_pc_o);
    end
    // Pop while full with fetch still offering 0x1008: the push must be refused.
    fetch_valid_i = 1'b1; fetch_pc_i = 64'h1008; decode_ready_i = 1'b1;
    step();
    idle();
    vectors++; if (decode_pc_o !== 64'h1004) begin miscompares++; $display("FAIL pop_next_pc: got %h want 1004", decode_pc_o); end
    vectors++; if (count_o !== 2'd1) begin miscompares++; $display("FAIL pop_count: got %0d want 1", count_o); end
    vectors++; if (fetch_ready_o !== 1'b1) begin miscompares++; $display("FAIL pop_ready: got %b want 1", fetch_ready_o); end
    clear();
  endtask

  task automatic test_streaming();
    int wr_idx = 0;
    int rd_idx = 0;
    int model_cnt = 0;
    int cycles = 0;
    logic p, q;
    while (rd_idx < 10 && cycles < 300) begin
      fetch_valid_i  = (wr_idx < 10) && ($urandom_range(0, 3) != 0);
      fetch_pc_i     = 64'h2000 + 64'(4 * wr_idx);
      fetch_instr_i  = 32'(wr_idx);
      decode_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      p = fetch_valid_i && fetch_ready_o;
      q = decode_valid_o && decode_ready_i;
      if (q) begin
        vectors++; if (decode_pc_o !== 64'h2000 + 64'(4 * rd_idx)) begin
          miscompares++; $display("FAIL stream_order%0d: got %h want %h", rd_idx, decode_pc_o, 64'h2000 + 64'(4 * rd_idx));
        end
        rd_idx++;
      end
      if (p) wr_idx++;
      step();
      model_cnt = model_cnt + (p ? 1 : 0) - (q ? 1 : 0);
      vectors++; if (count_o !== 2'(model_cnt) || model_cnt > 2) begin
        miscompares++; $display("FAIL stream_count: got %0d want %0d", count_o, model_cnt);
      end
      cycles++;
    end
    vectors++; if (rd_idx != 10) begin miscompares++; $display("FAIL stream_timeout: got %0d pops want 10", rd_idx); end
    idle();
  endtask

  task automatic test_flush();
    push(64'h1000, 32'h13);
    push(64'h1004, 32'h13);
    flush_i = 1'b1; fetch_valid_i = 1'b1; fetch_pc_i = 64'h3000; decode_ready_i = 1'b1;
    step();
    idle();
    vectors++; if (count_o !== 2'd0 || decode_valid_o !== 1'b0 || fetch_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL flush_state: got count=%0d valid=%b ready=%b want 0/0/1", count_o, decode_valid_o, fetch_ready_o);
    end
    push(64'h4000, 32'h13);
    vectors++; if (decode_pc_o !== 64'h4000 || count_o !== 2'd1) begin
      miscompares++; $display("FAIL flush_refill: got pc=%h count=%0d want 4000/1", decode_pc_o, count_o);
    end
    clear();
  endtask

  task automatic test_misaligned();
    push(64'h1002, 32'h13);
    vectors++; if (decode_misaligned_o !== 1'b1 || decode_pc_o !== 64'h1002) begin
      miscompares++; $display("FAIL mis_set: got mis=%b pc=%h want 1/1002", decode_misaligned_o, decode_pc_o);
    end
    decode_ready_i = 1'b1;
    push(64'h1004, 32'h13);
    decode_ready_i = 1'b0;
    vectors++; if (decode_misaligned_o !== 1'b0 || decode_pc_o !== 64'h1004 || count_o !== 2'd1) begin
      miscompares++; $display("FAIL mis_clear: got mis=%b pc=%h count=%0d want 0/1004/1", decode_misaligned_o, decode_pc_o, count_o);
    end
    clear();
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_fill();
    test_streaming();
    test_flush();
    test_misaligned();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

- Decoupling buffer between the fetch stage and the decode stage.
- Captures each fetched {PC, instruction} pair with a valid/ready handshake and presents the pairs to decode in order.
- Absorbs decode back-pressure, so fetch keeps running until the buffer is full.
- Supports a single-cycle flush, which the branch/exception redirect logic uses to discard wrong-path instructions.

## Interface
- XLEN, 64, address/PC width in bits.
- ILEN, 32, instruction width in bits.
- DEPTH, 2, number of entries; must be a power of two and ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- flush_i  input  1  discard all buffered entries this cycle.
- fetch_valid_i  input  1  fetch presents a valid {PC, instruction} pair.
- fetch_ready_o  output  1  the buffer can accept a pair this cycle.
- fetch_pc_i  input  XLEN  PC of the presented instruction.
- fetch_instr_i  input  ILEN  the presented instruction word.
- decode_valid_o  output  1  the head entry is valid.
- decode_ready_i  input  1  decode consumes the head entry this cycle.
- decode_pc_o  output  XLEN  PC of the head entry.
- decode_instr_o  output  ILEN  instruction of the head entry.
- decode_misaligned_o  output  1  the head entry's PC has PC[1:0] != 0.
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Circular buffer with a write pointer, a read pointer and an occupancy counter. Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- **Push:** happens when fetch_valid_i && fetch_ready_o && !flush_i.
  - Writes {fetch_pc_i, fetch_instr_i, misaligned = |fetch_pc_i[1:0]} at the write pointer.
  - Advances the write pointer.
- **Pop:** happens when decode_valid_o && decode_ready_i && !flush_i. Advances the read pointer.
- **Occupancy update:**
  - count += 1 on push only.
  - count -= 1 on pop only.
  - count is unchanged on simultaneous push and pop.
- **Ready and valid:**
  - fetch_ready_o = (count != DEPTH).
  - fetch_ready_o is a function of registered state only; there is no combinational path from decode_ready_i or flush_i.
  - decode_valid_o = (count != 0).
- **Output data:**
  - decode_pc_o, decode_instr_o and decode_misaligned_o are driven from the entry at the read pointer when decode_valid_o = 1.
  - They are forced to 0 when decode_valid_o = 0.
- **Flush:** when flush_i = 1, on the next edge:
  - count, the write pointer and the read pointer all go to 0;
  - any push or pop in the same cycle is ignored;
  - storage contents need not be cleared.
- **Misaligned entries:** the misaligned flag is carried, not acted on. The buffer never drops or alters an entry.
- **Data stability:**
  - While decode_valid_o = 1 and decode_ready_i = 0, the head outputs hold stable.
  - Fetch data and PC are sampled only on a push; they are don't-care when fetch_valid_i = 0.

## Timing
- **Reset values:** while reset is asserted, and on the first edge after deassertion:
  - count_o = 0 and both pointers = 0;
  - decode_valid_o = 0, decode_pc_o = 0, decode_instr_o = 0, decode_misaligned_o = 0;
  - fetch_ready_o = 1.
- **Reset mid-operation:** asynchronous; all buffered entries are lost immediately, without waiting for a clock edge.
- **Latency:** a pair pushed at edge N is visible on the decode outputs after edge N (next cycle) if the buffer was empty. Fill latency is 1 cycle; there is no combinational bypass.
- **Throughput:** 1 pair/cycle sustained when decode_ready_i = 1 continuously.
- **Full:** push is refused while count = DEPTH, even if decode pops that cycle. fetch_ready_o rises the cycle after the pop.
- **Empty:** a pop is impossible. decode_ready_i is ignored while decode_valid_o = 0.
- **Pointer wrap:** after DEPTH pushes, the write pointer returns to 0. FIFO ordering must be preserved across the wrap.
- **Flush priority:** a flush coinciding with push, pop or full state takes priority.
  - In the cycle after the flush: count_o = 0, decode_valid_o = 0, fetch_ready_o = 1.
  - A push presented in that following cycle is accepted normally.

## Test plan
- **Reset:** assert reset mid-stream with count = 2.
  - Expect immediately: decode_valid_o = 0, count_o = 0, fetch_ready_o = 1, all data outputs 0.
- **Single pass:**
  - Stimulus: push {pc=0x1000, instr=0x00000013} into the empty buffer with decode_ready_i = 0.
  - Next cycle: decode_valid_o = 1, decode_pc_o = 0x1000, decode_instr_o = 0x00000013, count_o = 1.
  - Outputs hold for 5 stalled cycles.
- **Fill/back-pressure:**
  - Stimulus: push pc=0x1000 and then 0x1004 with decode stalled.
  - Expect count_o = 2 and fetch_ready_o = 0; a third pair at 0x1008 is not accepted.
  - Then pop once: expect decode_pc_o = 0x1004 next, and fetch_ready_o = 1 one cycle after the pop.
- **Streaming/wrap:**
  - Stimulus: 10 consecutive pushes (pc 0x2000 + 4*i), decode_ready_i = 1, with the valid/ready pattern randomized.
  - Expect decode to see all 10 PCs in order with no loss or duplication, and count_o never > 2.
- **Flush:**
  - Stimulus: with count = 2, assert flush_i together with fetch_valid_i (pc=0x3000) and decode_ready_i = 1.
  - Next cycle: count_o = 0, decode_valid_o = 0; pc 0x3000 is not buffered.
  - Then a push of pc=0x4000 appears at the output one cycle later.
- **Misaligned tag:**
  - Push pc=0x1002: expect decode_misaligned_o = 1 with that entry.
  - Push pc=0x1004 next: expect decode_misaligned_o = 0.
